// File: rtl/alu_defs.sv
// Shared ALU/MDU control encodings and FSM state types, so the ALU, alu_ctl and the
// multiply/divide unit all decode ctl from one place.
package alu_defs;

  localparam logic [5:0] CtlAdd   = 6'd32;
  localparam logic [5:0] CtlSub   = 6'd34;
  localparam logic [5:0] CtlMult  = 6'd24;
  localparam logic [5:0] CtlMultu = 6'd25;
  localparam logic [5:0] CtlDiv   = 6'd26;
  localparam logic [5:0] CtlDivu  = 6'd27;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2
  } mdu_state_e;

  typedef enum logic [1:0] {
    ClsNone = 2'd0,
    ClsAlu  = 2'd1,
    ClsMul  = 2'd2,
    ClsDiv  = 2'd3
  } ctl_class_e;

  function automatic ctl_class_e ctl_class(input logic [5:0] ctl);
    ctl_class_e cls;
    cls = ClsNone;
    case (ctl)
      CtlAdd, CtlSub:    cls = ClsAlu;
      CtlMult, CtlMultu: cls = ClsMul;
      CtlDiv, CtlDivu:   cls = ClsDiv;
      default:           cls = ClsNone;
    endcase
    return cls;
  endfunction

  function automatic logic ctl_is_signed(input logic [5:0] ctl);
    return (ctl == CtlMult) || (ctl == CtlDiv);
  endfunction

endpackage

// File: rtl/mdu_cond_neg.sv
// Conditional two's-complement negate: o_val = i_neg ? -i_val : i_val (modulo 2^WIDTH).
module mdu_cond_neg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS mult/multu/div/divu unit owning HI/LO: one bit per cycle on magnitudes,
// then a single sign-fix cycle. start/busy/done handshake lets EX stall around it.
import alu_defs::*;

module mul_div_unit #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  mdu_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_dz;
  logic               r_neg_res;
  logic               r_neg_a;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_dbz;

  ctl_class_e         w_cls;
  logic               w_accept;
  logic               w_is_div;
  logic               w_dz;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_rem_diff;
  logic               w_q_bit;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_cls    = ctl_class(ctl);
  assign w_is_div = (w_cls == ClsDiv);
  assign w_accept = (r_state == StIdle) && start && ((w_cls == ClsMul) || w_is_div);
  assign w_dz     = w_is_div && (b == '0);
  assign w_neg_a  = ctl_is_signed(ctl) && a[WIDTH-1];
  assign w_neg_b  = ctl_is_signed(ctl) && b[WIDTH-1];

  mdu_cond_neg #(.WIDTH(WIDTH)) u_mag_a (
    .i_val (a),
    .i_neg (w_neg_a),
    .o_val (w_mag_a)
  );

  mdu_cond_neg #(.WIDTH(WIDTH)) u_mag_b (
    .i_val (b),
    .i_neg (w_neg_b),
    .o_val (w_mag_b)
  );

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, then shift right with carry.
  assign w_addend   = r_acc[0] ? r_opnd : '0;
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: dividend shifts out of acc[WIDTH-1], quotient bits shift in at acc[0].
  assign w_rem_sh   = (r_rem << 1) | {{WIDTH{1'b0}}, r_acc[WIDTH-1]};
  assign w_rem_diff = w_rem_sh - {1'b0, r_opnd};
  assign w_q_bit    = ~w_rem_diff[WIDTH];
  assign w_div_next = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_q_bit};

  mdu_cond_neg #(.WIDTH(2 * WIDTH)) u_fix_prod (
    .i_val (r_acc),
    .i_neg (r_neg_res),
    .o_val (w_prod)
  );

  mdu_cond_neg #(.WIDTH(WIDTH)) u_fix_quo (
    .i_val (r_acc[WIDTH-1:0]),
    .i_neg (r_neg_res),
    .o_val (w_quo)
  );

  mdu_cond_neg #(.WIDTH(WIDTH)) u_fix_rem (
    .i_val (r_rem[WIDTH-1:0]),
    .i_neg (r_neg_a),
    .o_val (w_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_dz      <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_a   <= 1'b0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_dbz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_busy    <= 1'b1;
            r_dbz     <= 1'b0;
            r_cnt     <= '0;
            r_is_div  <= w_is_div;
            r_dz      <= w_dz;
            r_neg_res <= w_neg_a ^ w_neg_b;
            r_neg_a   <= w_neg_a;
            r_rem     <= '0;
            if (w_is_div) begin
              r_opnd <= w_mag_b;
              // Divide by zero keeps raw a so FIX can return it in hi.
              r_acc  <= {{WIDTH{1'b0}}, (w_dz ? a : w_mag_a)};
            end else begin
              r_opnd <= w_mag_a;
              r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
            end
            r_state <= w_dz ? StFix : StCalc;
          end
        end
        StCalc: begin
          if (r_is_div) begin
            r_acc <= w_div_next;
            r_rem <= w_q_bit ? w_rem_diff : w_rem_sh;
          end else begin
            r_acc <= w_mul_next;
          end
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= StFix;
          end
        end
        StFix: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          if (r_dz) begin
            r_hi  <= r_acc[WIDTH-1:0];
            r_lo  <= '1;
            r_dbz <= 1'b1;
          end else if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32) with hand-computed results.
module tb_mul_div_unit;

  localparam logic [5:0] OpMult  = 6'd24;
  localparam logic [5:0] OpMultu = 6'd25;
  localparam logic [5:0] OpDiv   = 6'd26;
  localparam logic [5:0] OpDivu  = 6'd27;
  localparam logic [5:0] OpAdd   = 6'd32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  ctl;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int checks;
  int failures;
  int lat;
  int busy_cnt;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ctl         (ctl),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one op for a single rising edge, then return #1 after that edge with start low.
  task automatic launch(input logic [5:0] op, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    start = 1'b1;
    ctl   = op;
    a     = va;
    b     = vb;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // lat = edges after acceptance until done is seen; a synchronous consumer samples it one
  // edge later, so the E0->done latency is lat+1.
  task automatic wait_done(input string name);
    lat      = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (done !== 1'b1) begin
      $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done, lat);
      failures++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    ctl   = '0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      $display("FAIL reset_flags: busy/done/dbz=%b required 000", {busy, done, div_by_zero});
      failures++;
    end
    checks++;
    if ({hi, lo} !== 64'h0) begin
      $display("FAIL reset_hilo: hi=%h lo=%h required 0/0", hi, lo);
      failures++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, hi, lo} !== 66'h0) begin
      $display("FAIL reset_idle: busy=%b done=%b hi=%h lo=%h required all 0", busy, done, hi, lo);
      failures++;
    end
  endtask

  task automatic test_multu_max;
    launch(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max");
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      $display("FAIL multu_max: hi=%h lo=%h required FFFFFFFE/00000001", hi, lo);
      failures++;
    end
    checks++;
    if (lat + 1 !== 34) begin
      $display("FAIL multu_latency: got %0d required 34", lat + 1);
      failures++;
    end
    checks++;
    if (busy_cnt !== 33) begin
      $display("FAIL multu_busy_cycles: got %0d required 33", busy_cnt);
      failures++;
    end
    checks++;
    if (busy !== 1'b0 || div_by_zero !== 1'b0) begin
      $display("FAIL multu_flags: busy=%b dbz=%b required 0/0", busy, div_by_zero);
      failures++;
    end
  endtask

  task automatic test_mult_signed;
    launch(OpMult, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult_neg_pos");
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      $display("FAIL mult_neg_pos: hi=%h lo=%h required FFFFFFFF/FFFFFFF1", hi, lo);
      failures++;
    end
    launch(OpMult, 32'hFFFF_FFFC, 32'hFFFF_FFFA);
    wait_done("mult_neg_neg");
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0000_0018) begin
      $display("FAIL mult_neg_neg: hi=%h lo=%h required 00000000/00000018", hi, lo);
      failures++;
    end
  endtask

  task automatic test_divide;
    launch(OpDivu, 32'd100, 32'd7);
    wait_done("divu_100_7");
    checks++;
    if (lo !== 32'h0000_000E || hi !== 32'h0000_0002) begin
      $display("FAIL divu_100_7: lo=%h hi=%h required 0000000E/00000002", lo, hi);
      failures++;
    end
    launch(OpDiv, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_m7_2");
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      $display("FAIL div_m7_2: lo=%h hi=%h required FFFFFFFD/FFFFFFFF", lo, hi);
      failures++;
    end
    launch(OpDiv, 32'd7, 32'hFFFF_FFFE);
    wait_done("div_7_m2");
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'h0000_0001) begin
      $display("FAIL div_7_m2: lo=%h hi=%h required FFFFFFFD/00000001", lo, hi);
      failures++;
    end
    launch(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_overflow");
    checks++;
    if (lo !== 32'h8000_0000 || hi !== 32'h0 || div_by_zero !== 1'b0) begin
      $display("FAIL div_overflow: lo=%h hi=%h dbz=%b required 80000000/00000000/0",
               lo, hi, div_by_zero);
      failures++;
    end
  endtask

  task automatic test_div_by_zero;
    launch(OpDivu, 32'h0000_1234, 32'd0);
    wait_done("divu_zero");
    checks++;
    if (hi !== 32'h0000_1234 || lo !== 32'hFFFF_FFFF || div_by_zero !== 1'b1) begin
      $display("FAIL divu_zero: hi=%h lo=%h dbz=%b required 00001234/FFFFFFFF/1",
               hi, lo, div_by_zero);
      failures++;
    end
    checks++;
    if (lat + 1 !== 2 || busy_cnt !== 1) begin
      $display("FAIL divu_zero_timing: latency=%0d busy=%0d required 2/1", lat + 1, busy_cnt);
      failures++;
    end
    launch(OpDivu, 32'd100, 32'd7);
    checks++;
    if (div_by_zero !== 1'b0 || hi !== 32'h0000_1234) begin
      $display("FAIL dbz_clear_on_start: dbz=%b hi=%h required 0/00001234", div_by_zero, hi);
      failures++;
    end
    wait_done("divu_after_zero");
    checks++;
    if (lo !== 32'h0000_000E || hi !== 32'h0000_0002 || div_by_zero !== 1'b0) begin
      $display("FAIL divu_after_zero: lo=%h hi=%h dbz=%b required 0000000E/00000002/0",
               lo, hi, div_by_zero);
      failures++;
    end
  endtask

  task automatic test_ignored_start;
    launch(OpMult, 32'hFFFF_FFFD, 32'd5);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    ctl   = OpDivu;
    a     = 32'd9;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || hi !== 32'h0000_0002 || lo !== 32'h0000_000E) begin
      $display("FAIL hold_while_busy: busy=%b hi=%h lo=%h required 1/00000002/0000000E",
               busy, hi, lo);
      failures++;
    end
    wait_done("mult_ignored_start");
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      $display("FAIL start_ignored: hi=%h lo=%h required FFFFFFFF/FFFFFFF1", hi, lo);
      failures++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL no_second_op: busy=%b done=%b required 0/0", busy, done);
      failures++;
    end
  endtask

  task automatic test_invalid_ctl;
    launch(OpAdd, 32'd5, 32'd6);
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL invalid_ctl_busy: busy=%b required 0", busy);
      failures++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      $display("FAIL invalid_ctl_idle: done=%b hi=%h lo=%h required 0/FFFFFFFF/FFFFFFF1",
               done, hi, lo);
      failures++;
    end
  endtask

  task automatic test_back_to_back;
    launch(OpDivu, 32'd100, 32'd7);
    wait_done("b2b_first");
    // Still inside the done cycle: the next edge sees start while the FSM is idle.
    start = 1'b1;
    ctl   = OpMultu;
    a     = 32'd6;
    b     = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || hi !== 32'h2 || lo !== 32'hE) begin
      $display("FAIL b2b_accept: busy=%b done=%b hi=%h lo=%h required 1/0/00000002/0000000E",
               busy, done, hi, lo);
      failures++;
    end
    wait_done("b2b_second");
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0000_002A) begin
      $display("FAIL b2b_result: hi=%h lo=%h required 00000000/0000002A", hi, lo);
      failures++;
    end
  endtask

  task automatic test_reset_mid_op;
    int dones;
    launch(OpMult, 32'hFFFF_FFFD, 32'd5);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_by_zero, hi, lo} !== 67'h0) begin
      $display("FAIL async_reset: busy=%b done=%b dbz=%b hi=%h lo=%h required all 0",
               busy, done, div_by_zero, hi, lo);
      failures++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      $display("FAIL reset_discards_op: %0d busy/done cycles required 0", dones);
      failures++;
    end
    launch(OpMultu, 32'd6, 32'd7);
    wait_done("multu_after_reset");
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0000_002A) begin
      $display("FAIL multu_after_reset: hi=%h lo=%h required 00000000/0000002A", hi, lo);
      failures++;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_divide();
    test_div_by_zero();
    test_ignored_start();
    test_invalid_ctl();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
